jtcps1_cab_inputs: RTL and testbench



---
 rtl/jtcps1_cab_pkg.sv | 24 ++
 rtl/jtcps1_dbnc_bit.sv | 38 +++
 rtl/jtcps1_cab_inputs.sv | 197 +++++++++++++++++++
 tb/tb_jtcps1_cab_inputs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_cab_pkg.sv
// Shared constants and types for the CPS1 cabinet input conditioner.
package jtcps1_cab_pkg;

    localparam int unsigned TOTAL_BITS  = 48;
    localparam int unsigned JOY_BITS    = 10;
    localparam int unsigned NUM_PLAYERS = 4;
    localparam int unsigned START_BASE  = 0;
    localparam int unsigned COIN_BASE   = 4;
    localparam int unsigned JOY_BASE    = 8;
    localparam int unsigned BTN1_IDX    = 4;
    localparam int unsigned FRAME_W     = 4;

    typedef enum logic [1:0] {
        COIN_IDLE    = 2'd0,
        COIN_HOLD    = 2'd1,
        COIN_WAITREL = 2'd2
    } coin_state_t;

    // Button 1 is active low on the cabinet
    function automatic logic btn1_pressed(input logic [JOY_BITS-1:0] joy);
        return ~joy[BTN1_IDX];
    endfunction

endpackage

// File: rtl/jtcps1_dbnc_bit.sv
// One cabinet bit: 2-FF synchroniser followed by a tick-based debouncer.
module jtcps1_dbnc_bit #(
    parameter int unsigned DBNC_CNT = 3
)(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic dtick,
    output logic db
);

    logic [1:0] sync;
    logic [2:0] cnt;

    // Accept a change only after it persists for DBNC_CNT consecutive ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            cnt  <= '0;
            db   <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (dtick) begin
                if (sync[1] != db) begin
                    if (cnt + 3'd1 == 3'(DBNC_CNT)) begin
                        db  <= sync[1];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/jtcps1_cab_inputs.sv
// Cabinet input conditioner: sync + debounce all raw bits, sample once per
// frame at vblank start, stretch coin strobes. Per-player autofire on
// button 1 is compiled in with the JTCPS1_AUTOFIRE_EN macro.
module jtcps1_cab_inputs
    import jtcps1_cab_pkg::*;
#(
    parameter int unsigned DBNC_DIV    = 48000,
    parameter int unsigned DBNC_CNT    = 3,
    parameter int unsigned COIN_FRAMES = 3,
    parameter int unsigned AF_FRAMES   = 4
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    LVBL,
    input  logic [NUM_PLAYERS-1:0]  start_raw,
    input  logic [NUM_PLAYERS-1:0]  coin_raw,
    input  logic [JOY_BITS-1:0]     joy1_raw,
    input  logic [JOY_BITS-1:0]     joy2_raw,
    input  logic [JOY_BITS-1:0]     joy3_raw,
    input  logic [JOY_BITS-1:0]     joy4_raw,
    input  logic [NUM_PLAYERS-1:0]  af_en,
    output logic [NUM_PLAYERS-1:0]  start_button,
    output logic [NUM_PLAYERS-1:0]  coin_input,
    output logic [JOY_BITS-1:0]     joystick1,
    output logic [JOY_BITS-1:0]     joystick2,
    output logic [JOY_BITS-1:0]     joystick3,
    output logic [JOY_BITS-1:0]     joystick4,
    output logic                    frame_tick
);

    localparam int unsigned DIV_W = (DBNC_DIV > 1) ? $clog2(DBNC_DIV) : 1;

    logic [DIV_W-1:0]      pre_cnt;
    logic                  dtick_c;
    logic                  lvbl_q;
    logic [TOTAL_BITS-1:0] raw_all;
    logic [TOTAL_BITS-1:0] db;
    logic [NUM_PLAYERS-1:0][JOY_BITS-1:0] joy_db;
    logic [NUM_PLAYERS-1:0][JOY_BITS-1:0] joy_load_c;

    assign dtick_c = (pre_cnt == DIV_W'(DBNC_DIV - 1));
    assign raw_all = {joy4_raw, joy3_raw, joy2_raw, joy1_raw, coin_raw, start_raw};
    assign joy_db  = db[TOTAL_BITS-1:JOY_BASE];

    // Debounce tick prescaler
    always_ff @(posedge clk) begin
        if (rst)          pre_cnt <= '0;
        else if (dtick_c) pre_cnt <= '0;
        else              pre_cnt <= pre_cnt + DIV_W'(1);
    end

    for (genvar i = 0; i < TOTAL_BITS; i++) begin : g_dbnc
        jtcps1_dbnc_bit #(.DBNC_CNT(DBNC_CNT)) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_all[i]),
            .dtick (dtick_c),
            .db    (db[i])
        );
    end

    // Vblank start detection, one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            lvbl_q     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            lvbl_q     <= LVBL;
            frame_tick <= lvbl_q & ~LVBL;
        end
    end

`ifdef JTCPS1_AUTOFIRE_EN
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_af
        logic               active;
        logic               phase;
        logic [FRAME_W-1:0] cnt;
        logic               fire_c;
        logic               wrap_c;
        logic [JOY_BITS-1:0] load_c;

        assign fire_c = af_en[p] && btn1_pressed(joy_db[p]);
        assign wrap_c = (cnt == FRAME_W'(AF_FRAMES));
        assign joy_load_c[p] = load_c;

        // Button 1 toggles every AF_FRAMES frames, starting pressed
        always_comb begin
            load_c = joy_db[p];
            if (fire_c) load_c[BTN1_IDX] = active ? (wrap_c ? ~phase : phase) : 1'b0;
        end

        // Autofire phase advances once per frame while held
        always_ff @(posedge clk) begin
            if (rst) begin
                active <= 1'b0;
                phase  <= 1'b0;
                cnt    <= '0;
            end else if (frame_tick) begin
                if (fire_c) begin
                    if (!active) begin
                        active <= 1'b1;
                        phase  <= 1'b0;
                        cnt    <= FRAME_W'(1);
                    end else if (wrap_c) begin
                        phase <= ~phase;
                        cnt   <= FRAME_W'(1);
                    end else begin
                        cnt <= cnt + FRAME_W'(1);
                    end
                end else begin
                    active <= 1'b0;
                    phase  <= 1'b0;
                    cnt    <= '0;
                end
            end
        end
    end
`else
    logic af_unused;
    assign af_unused  = ^{af_en, FRAME_W'(AF_FRAMES)};
    assign joy_load_c = joy_db;
`endif

    // Frame-aligned output sampling; frozen between vblanks
    always_ff @(posedge clk) begin
        if (rst) begin
            start_button <= '1;
            joystick1    <= '1;
            joystick2    <= '1;
            joystick3    <= '1;
            joystick4    <= '1;
        end else if (frame_tick) begin
            start_button <= db[START_BASE +: NUM_PLAYERS];
            joystick1    <= joy_load_c[0];
            joystick2    <= joy_load_c[1];
            joystick3    <= joy_load_c[2];
            joystick4    <= joy_load_c[3];
        end
    end

    for (genvar c = 0; c < NUM_PLAYERS; c++) begin : g_coin
        coin_state_t        state, state_n;
        logic [FRAME_W-1:0] cnt, cnt_n;
        logic               coin_q, coin_n;

        assign coin_input[c] = coin_q;

        // Coin FSM state register
        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= COIN_IDLE;
                cnt    <= '0;
                coin_q <= 1'b1;
            end else begin
                state  <= state_n;
                cnt    <= cnt_n;
                coin_q <= coin_n;
            end
        end

        // One COIN_FRAMES-long low pulse per insertion, re-armed on release
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            coin_n  = coin_q;
            if (frame_tick) begin
                case (state)
                    COIN_IDLE: begin
                        if (!db[COIN_BASE + c]) begin
                            state_n = COIN_HOLD;
                            cnt_n   = FRAME_W'(1);
                            coin_n  = 1'b0;
                        end
                    end
                    COIN_HOLD: begin
                        if (cnt == FRAME_W'(COIN_FRAMES)) begin
                            state_n = COIN_WAITREL;
                            cnt_n   = '0;
                            coin_n  = 1'b1;
                        end else begin
                            cnt_n = cnt + FRAME_W'(1);
                        end
                    end
                    COIN_WAITREL: begin
                        if (db[COIN_BASE + c]) state_n = COIN_IDLE;
                    end
                    default: begin
                        state_n = COIN_IDLE;
                        cnt_n   = '0;
                        coin_n  = 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_cab_inputs.sv
// Scoreboard bench for jtcps1_cab_inputs with a frame-level reference model.
module tb_jtcps1_cab_inputs;

    localparam int unsigned DIV   = 4;
    localparam int unsigned CNT   = 3;
    localparam int unsigned COINF = 3;
    localparam int unsigned AFF   = 2;

    typedef struct packed {
        logic [3:0] start;
        logic [3:0] coin;
        logic [9:0] j1;
        logic [9:0] j2;
        logic [9:0] j3;
        logic [9:0] j4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        LVBL;
    logic [47:0] raw_bus;
    logic [3:0]  af_en;
    logic [3:0]  start_raw, coin_raw;
    logic [9:0]  joy1_raw, joy2_raw, joy3_raw, joy4_raw;
    logic [3:0]  start_button, coin_input;
    logic [9:0]  joystick1, joystick2, joystick3, joystick4;
    logic        frame_tick;

    always #5 clk = ~clk;

    assign start_raw = raw_bus[3:0];
    assign coin_raw  = raw_bus[7:4];
    assign joy1_raw  = raw_bus[17:8];
    assign joy2_raw  = raw_bus[27:18];
    assign joy3_raw  = raw_bus[37:28];
    assign joy4_raw  = raw_bus[47:38];

    jtcps1_cab_inputs #(
        .DBNC_DIV(DIV), .DBNC_CNT(CNT), .COIN_FRAMES(COINF), .AF_FRAMES(AFF)
    ) dut (
        .clk(clk), .rst(rst), .LVBL(LVBL),
        .start_raw(start_raw), .coin_raw(coin_raw),
        .joy1_raw(joy1_raw), .joy2_raw(joy2_raw), .joy3_raw(joy3_raw), .joy4_raw(joy4_raw),
        .af_en(af_en),
        .start_button(start_button), .coin_input(coin_input),
        .joystick1(joystick1), .joystick2(joystick2), .joystick3(joystick3), .joystick4(joystick4),
        .frame_tick(frame_tick)
    );

    int   checks = 0;
    int   errors = 0;
    int   ticks  = 0;
    exp_t exp_q[$];

    // Frame-level reference state
    exp_t mdl;
    exp_t held;
    int   coin_rem [4];
    bit   coin_wait[4];
    int   af_k     [4];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t dut_now();
        return {start_button, coin_input, joystick1, joystick2, joystick3, joystick4};
    endfunction

    task automatic chk_ones(input string name);
        chk({name, "_outs"}, 48'(dut_now()), '1);
        chk({name, "_tick"}, 48'(frame_tick), 48'(0));
    endtask

    task automatic model_reset();
        mdl = '1;
        for (int c = 0; c < 4; c++) begin
            coin_rem[c]  = 0;
            coin_wait[c] = 1'b0;
            af_k[c]      = 0;
        end
    endtask

    // Outputs after a frame tick, given the settled raw value and autofire enables
    task automatic model_tick(input logic [47:0] d, input logic [3:0] af);
        logic [9:0] j [4];
        mdl.start = d[3:0];
        for (int c = 0; c < 4; c++) begin
            logic dc;
            dc = d[4 + c];
            if (coin_rem[c] > 0) begin
                coin_rem[c]--;
                if (coin_rem[c] == 0) begin
                    mdl.coin[c]  = 1'b1;
                    coin_wait[c] = 1'b1;
                end else begin
                    mdl.coin[c] = 1'b0;
                end
            end else if (coin_wait[c]) begin
                mdl.coin[c] = 1'b1;
                if (dc) coin_wait[c] = 1'b0;
            end else if (!dc) begin
                mdl.coin[c]  = 1'b0;
                coin_rem[c]  = COINF;
            end else begin
                mdl.coin[c] = 1'b1;
            end
        end
        for (int p = 0; p < 4; p++) begin
            j[p] = d[8 + 10*p +: 10];
            if (af[p] && !j[p][4]) begin
`ifdef JTCPS1_AUTOFIRE_EN
                j[p][4] = (((af_k[p] / AFF) % 2) == 1);
`endif
                af_k[p]++;
            end else begin
                af_k[p] = 0;
            end
        end
        mdl.j1 = j[0];
        mdl.j2 = j[1];
        mdl.j3 = j[2];
        mdl.j4 = j[3];
    endtask

    // One frame: apply raw, optional glitch and optional mid-frame reset, then vblank
    task automatic run_frame(input logic [47:0] raw, input logic [3:0] af,
                             input int gbit, input int glen, input bit do_rst);
        int t;
        t = 0;
        raw_bus = raw;
        af_en   = af;
        if (do_rst) begin
            chk("pre_rst_coin", 48'(coin_input), 48'(mdl.coin));
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk_ones("rst_mid");
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            t = 6;
        end
        held = mdl;
        model_tick(raw, af);
        exp_q.push_back(mdl);
        while (t < 24) begin @(negedge clk); t++; end
        if (glen > 0) begin
            raw_bus[gbit] = ~raw[gbit];
            repeat (glen) @(negedge clk);
            raw_bus = raw;
            t += glen;
        end
        while (t < 47) begin @(negedge clk); t++; end
        chk("frozen", 48'(dut_now()), 48'(held));
        @(negedge clk);
        LVBL = 1'b0;
        repeat (16) @(negedge clk);
        LVBL = 1'b1;
    endtask

    // Monitor: on each frame tick, compare outputs one clk later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ticks++;
                @(negedge clk);
                chk("tick_width", 48'(frame_tick), 48'(0));
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", 48'(1), 48'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("start", 48'(start_button), 48'(e.start));
                    chk("coin",  48'(coin_input),   48'(e.coin));
                    chk("joy1",  48'(joystick1),    48'(e.j1));
                    chk("joy2",  48'(joystick2),    48'(e.j2));
                    chk("joy3",  48'(joystick3),    48'(e.j3));
                    chk("joy4",  48'(joystick4),    48'(e.j4));
                end
            end
        end
    end

    initial begin
        logic [47:0] base;
        logic [47:0] cur;
        logic [47:0] mask;
        logic [3:0]  af;
        int          tick0;

        rst     = 1'b1;
        LVBL    = 1'b1;
        raw_bus = '0;
        af_en   = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_ones("rst_hold");
        end
        rst = 1'b0;
        @(negedge clk);
        chk_ones("rst_after");
        model_reset();

        base = '1;
        repeat (2) run_frame(base, 4'h0, 0, 0, 1'b0);

        // Glitch rejection on joy1[0]
        repeat (3) run_frame(base, 4'h0, 8, 8, 1'b0);

        // Valid press on joy2[3], then release
        cur = base; cur[21] = 1'b0;
        run_frame(cur, 4'h0, 0, 0, 1'b0);
        repeat (2) run_frame(base, 4'h0, 0, 0, 1'b0);

        // Coin stretch, release, re-press
        cur = base; cur[4] = 1'b0;
        repeat (10) run_frame(cur, 4'h0, 0, 0, 1'b0);
        repeat (2)  run_frame(base, 4'h0, 0, 0, 1'b0);
        repeat (5)  run_frame(cur, 4'h0, 0, 0, 1'b0);
        repeat (2)  run_frame(base, 4'h0, 0, 0, 1'b0);

        // Autofire request on player 1 button 1
        cur = base; cur[12] = 1'b0;
        repeat (8) run_frame(cur, 4'h1, 0, 0, 1'b0);
        repeat (2) run_frame(base, 4'h1, 0, 0, 1'b0);

        // Reset during frame 2 of a coin pulse with the coin still held
        cur = base; cur[5] = 1'b0;
        repeat (2) run_frame(cur, 4'h0, 0, 0, 1'b0);
        run_frame(cur, 4'h0, 0, 0, 1'b1);
        repeat (5) run_frame(cur, 4'h0, 0, 0, 1'b0);
        repeat (2) run_frame(base, 4'h0, 0, 0, 1'b0);

        // Random walk on all inputs
        cur = base;
        af  = 4'h0;
        for (int f = 0; f < 150; f++) begin
            int gb, gl;
            mask = {16'($urandom & $urandom & $urandom), 32'($urandom & $urandom & $urandom)};
            cur  = cur ^ mask;
            if ($urandom_range(7, 0) == 0) af = 4'($urandom);
            gb = int'($urandom_range(47, 0));
            gl = ($urandom_range(1, 0) == 1) ? int'($urandom_range(8, 1)) : 0;
            run_frame(cur, af, gb, gl, 1'b0);
        end

        // LVBL held high: no ticks, outputs frozen
        tick0 = ticks;
        held  = mdl;
        repeat (6) begin
            raw_bus = {16'($urandom), 32'($urandom)};
            repeat (50) @(negedge clk);
        end
        chk("no_tick_const_lvbl", 48'(ticks - tick0), 48'(0));
        chk("frozen_const_lvbl", 48'(dut_now()), 48'(held));
        chk("queue_empty", 48'(exp_q.size()), 48'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
